// File: rtl/load_store_unit.sv
// RV32I data-memory access stage: word-wide BlockRam loads, stores and
// read-modify-write sub-word stores, with little-endian lane extraction.
module load_store_unit #(
    parameter int unsigned ADDRESS_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_is_store,
    input  logic [2:0]               req_funct3,
    input  logic [31:0]              req_address,
    input  logic [31:0]              req_store_data,
    output logic                     resp_valid,
    output logic [31:0]              resp_load_data,
    output logic                     resp_misaligned,
    output logic [ADDRESS_WIDTH-3:0] ram_address,
    output logic                     ram_write,
    output logic [31:0]              ram_write_data,
    input  logic [31:0]              ram_read_data
);

    localparam int unsigned WORD_AW = ADDRESS_WIDTH - 2;

    typedef enum logic [2:0] {
        IDLE, LD_ADDR, LD_DATA, ST_WRITE, RMW_ADDR, RMW_MERGE, RMW_WRITE, RESP
    } state_e;

    state_e               state_q, state_d;
    logic                 ready_q, ready_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 resp_mis_q, resp_mis_d;
    logic [31:0]          resp_data_q, resp_data_d;
    logic [WORD_AW-1:0]   ram_addr_q, ram_addr_d;
    logic                 ram_write_q, ram_write_d;
    logic [31:0]          ram_wdata_q, ram_wdata_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [1:0]           lane_q, lane_d;
    logic [15:0]          st_data_q, st_data_d;

    logic                 illegal_c, misaligned_c;
    logic [7:0]           rd_byte_c;
    logic [15:0]          rd_half_c;
    logic [31:0]          load_ext_c, merged_c;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^req_address[31:ADDRESS_WIDTH];

    // Request classification; legality of the width depends on direction
    always_comb begin
        illegal_c    = 1'b0;
        misaligned_c = 1'b0;
        if (req_is_store) begin
            illegal_c = (req_funct3 >= 3'b011);
        end else begin
            illegal_c = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                        (req_funct3 == 3'b111);
        end
        if (req_funct3[1:0] == 2'b01) begin
            misaligned_c = req_address[0];
        end else if (req_funct3[1:0] == 2'b10) begin
            misaligned_c = (req_address[1:0] != 2'b00);
        end
    end

    assign rd_byte_c = ram_read_data[{lane_q, 3'b000} +: 8];
    assign rd_half_c = lane_q[1] ? ram_read_data[31:16] : ram_read_data[15:0];

    // Load extension and sub-word store merge from the RAM read word
    always_comb begin
        load_ext_c = ram_read_data;
        merged_c   = ram_read_data;
        case (funct3_q)
            3'b000:  load_ext_c = {{24{rd_byte_c[7]}}, rd_byte_c};
            3'b001:  load_ext_c = {{16{rd_half_c[15]}}, rd_half_c};
            3'b100:  load_ext_c = {24'h0, rd_byte_c};
            3'b101:  load_ext_c = {16'h0, rd_half_c};
            default: load_ext_c = ram_read_data;
        endcase
        if (funct3_q[0]) begin
            merged_c[{lane_q[1], 4'b0000} +: 16] = st_data_q;
        end else begin
            merged_c[{lane_q, 3'b000} +: 8] = st_data_q[7:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_mis_d   = 1'b0;
        resp_data_d  = '0;
        ram_write_d  = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        funct3_d     = funct3_q;
        lane_d       = lane_q;
        st_data_d    = st_data_q;
        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    funct3_d  = req_funct3;
                    lane_d    = req_address[1:0];
                    st_data_d = req_store_data[15:0];
                    if (illegal_c || misaligned_c) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_mis_d   = 1'b1;
                    end else begin
                        ram_addr_d = req_address[ADDRESS_WIDTH-1:2];
                        if (!req_is_store) begin
                            state_d = LD_ADDR;
                        end else if (req_funct3 == 3'b010) begin
                            state_d     = ST_WRITE;
                            ram_write_d = 1'b1;
                            ram_wdata_d = req_store_data;
                        end else begin
                            state_d = RMW_ADDR;
                        end
                    end
                end
            end
            LD_ADDR:  state_d = LD_DATA;
            LD_DATA: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_data_d  = load_ext_c;
            end
            ST_WRITE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            RMW_ADDR: state_d = RMW_MERGE;
            RMW_MERGE: begin
                state_d     = RMW_WRITE;
                ram_write_d = 1'b1;
                ram_wdata_d = merged_c;
            end
            RMW_WRITE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_mis_q   <= 1'b0;
            resp_data_q  <= '0;
            ram_addr_q   <= '0;
            ram_write_q  <= 1'b0;
            ram_wdata_q  <= '0;
            funct3_q     <= '0;
            lane_q       <= '0;
            st_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_mis_q   <= resp_mis_d;
            resp_data_q  <= resp_data_d;
            ram_addr_q   <= ram_addr_d;
            ram_write_q  <= ram_write_d;
            ram_wdata_q  <= ram_wdata_d;
            funct3_q     <= funct3_d;
            lane_q       <= lane_d;
            st_data_q    <= st_data_d;
        end
    end

    assign req_ready       = ready_q;
    assign resp_valid      = resp_valid_q;
    assign resp_misaligned = resp_mis_q;
    assign resp_load_data  = resp_data_q;
    assign ram_address     = ram_addr_q;
    assign ram_write       = ram_write_q;
    assign ram_write_data  = ram_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit against a synchronous-read word RAM model.
module tb_load_store_unit;

    localparam int unsigned AW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_is_store;
    logic [2:0]    req_funct3;
    logic [31:0]   req_address;
    logic [31:0]   req_store_data;
    logic          resp_valid;
    logic [31:0]   resp_load_data;
    logic          resp_misaligned;
    logic [AW-3:0] ram_address;
    logic          ram_write;
    logic [31:0]   ram_write_data;
    logic [31:0]   ram_read_data;

    load_store_unit #(.ADDRESS_WIDTH(AW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_funct3(req_funct3),
        .req_address(req_address), .req_store_data(req_store_data),
        .resp_valid(resp_valid), .resp_load_data(resp_load_data),
        .resp_misaligned(resp_misaligned),
        .ram_address(ram_address), .ram_write(ram_write),
        .ram_write_data(ram_write_data), .ram_read_data(ram_read_data)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] data;
        logic        mis;
    } exp_t;

    exp_t        sb_q[$];
    int          acc_log[$];
    int          n_checks = 0;
    int          n_bad    = 0;
    int          cyc      = 0;
    int          acc_n    = 0;
    int          acc_cyc  = 0;
    int          resp_n   = 0;
    int          resp_cyc = 0;
    int          wr_n     = 0;
    logic [31:0] last_wr_data = '0;
    logic [AW-3:0] last_wr_addr = '0;
    logic [AW-3:0] c1_addr = '0;

    logic [31:0]   mem [0:(1 << (AW-2)) - 1];
    logic          bd_we = 1'b0;
    logic [AW-3:0] bd_addr = '0;
    logic [31:0]   bd_data = '0;

    // Word RAM: read data valid the cycle after the address; backdoor port for preload
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (ram_write) mem[ram_address] <= ram_write_data;
        ram_read_data <= mem[ram_address];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Output monitor and scoreboard, sampled mid-cycle
    always @(negedge clock) begin
        if (!reset) begin
            if (req_valid && req_ready) begin
                acc_cyc = cyc;
                acc_n++;
                acc_log.push_back(cyc);
            end
            if (cyc == acc_cyc + 1) c1_addr = ram_address;
            if (ram_write) begin
                wr_n++;
                last_wr_addr = ram_address;
                last_wr_data = ram_write_data;
            end
            if (resp_valid) begin
                resp_n++;
                resp_cyc = cyc;
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check_eq("resp_data", resp_load_data, e.data);
                    check_eq("resp_mis", 32'(resp_misaligned), 32'(e.mis));
                end
            end
        end
    end

    task automatic poke(input logic [AW-3:0] a, input logic [31:0] d);
        @(posedge clock); #1;
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clock); #1;
        bd_we = 1'b0;
    endtask

    task automatic wait_ready();
        int k;
        for (k = 0; k < 20; k++) begin
            if (req_ready) break;
            @(posedge clock); #1;
        end
        if (k == 20) check_eq("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_resp(input int target);
        int k;
        for (k = 0; k < 20; k++) begin
            if (resp_n >= target) break;
            @(posedge clock); #1;
        end
        if (k == 20) check_eq("resp_timeout", 32'(resp_n), 32'(target));
    endtask

    task automatic do_req(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] exp_data, input logic exp_mis,
                          input int exp_lat);
        int r0;
        exp_t e;
        @(posedge clock); #1;
        wait_ready();
        r0 = resp_n;
        e.data = exp_data; e.mis = exp_mis;
        sb_q.push_back(e);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
        req_address = addr; req_store_data = sdata;
        @(posedge clock); #1;
        req_valid = 1'b0;
        req_address = 32'hDEAD_BEEF; req_store_data = 32'hA5A5_A5A5;
        wait_resp(r0 + 1);
        check_eq({tag, "_lat"}, 32'(resp_cyc - acc_cyc), 32'(exp_lat));
    endtask

    initial begin
        int w0, r0, a0, k;
        logic [31:0] snap;
        reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0;
        req_funct3 = '0; req_address = '0; req_store_data = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_eq("rst_ready", 32'(req_ready), 32'd1);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_ram_write", 32'(ram_write), 32'd0);
        check_eq("rst_ram_addr", 32'(ram_address), 32'd0);
        check_eq("rst_wdata", ram_write_data, 32'd0);
        check_eq("rst_ldata", resp_load_data, 32'd0);

        // Sub-word loads with sign/zero extension
        poke(14'h20, 32'h8899_AABB);
        do_req("lb",  1'b0, 3'b000, 32'h81, 32'h0, 32'hFFFF_FFAA, 1'b0, 3);
        do_req("lbu", 1'b0, 3'b100, 32'h83, 32'h0, 32'h0000_0088, 1'b0, 3);
        do_req("lh",  1'b0, 3'b001, 32'h82, 32'h0, 32'hFFFF_8899, 1'b0, 3);
        do_req("lhu", 1'b0, 3'b101, 32'h80, 32'h0, 32'h0000_AABB, 1'b0, 3);
        do_req("lw",  1'b0, 3'b010, 32'h80, 32'h0, 32'h8899_AABB, 1'b0, 3);

        // Word store then load back
        w0 = wr_n;
        do_req("sw", 1'b1, 3'b010, 32'h40, 32'h1234_5678, 32'h0, 1'b0, 2);
        check_eq("sw_wr_count", 32'(wr_n - w0), 32'd1);
        check_eq("sw_wr_addr", 32'(last_wr_addr), 32'h10);
        check_eq("sw_wr_data", last_wr_data, 32'h1234_5678);
        do_req("lw_back", 1'b0, 3'b010, 32'h40, 32'h0, 32'h1234_5678, 1'b0, 3);

        // Read-modify-write byte and half stores
        poke(14'h10, 32'h1122_3344);
        do_req("sb", 1'b1, 3'b000, 32'h41, 32'hFFFF_FFCD, 32'h0, 1'b0, 4);
        check_eq("sb_wr_data", last_wr_data, 32'h1122_CD44);
        check_eq("sb_mem", mem[14'h10], 32'h1122_CD44);
        do_req("sh", 1'b1, 3'b001, 32'h42, 32'h0000_BEEF, 32'h0, 1'b0, 4);
        check_eq("sh_mem", mem[14'h10], 32'hBEEF_CD44);

        // Faults: misaligned and illegal widths never touch RAM
        w0 = wr_n;
        do_req("lw_mis", 1'b0, 3'b010, 32'h42, 32'h0, 32'h0, 1'b1, 1);
        do_req("sh_mis", 1'b1, 3'b001, 32'h43, 32'hFFFF, 32'h0, 1'b1, 1);
        do_req("st_ill", 1'b1, 3'b011, 32'h40, 32'h5555, 32'h0, 1'b1, 1);
        do_req("ld_ill", 1'b0, 3'b110, 32'h40, 32'h0, 32'h0, 1'b1, 1);
        check_eq("fault_no_write", 32'(wr_n - w0), 32'd0);
        check_eq("fault_mem", mem[14'h10], 32'hBEEF_CD44);

        // Reset during RMW merge cycle drops the request
        w0 = wr_n; r0 = resp_n; snap = mem[14'h10];
        @(posedge clock); #1;
        wait_ready();
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b000;
        req_address = 32'h41; req_store_data = 32'h77;
        @(posedge clock); #1;
        req_valid = 1'b0;
        check_eq("busy_ready", 32'(req_ready), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check_eq("post_rst_ready", 32'(req_ready), 32'd1);
        repeat (6) @(posedge clock);
        #1;
        check_eq("rst_no_write", 32'(wr_n - w0), 32'd0);
        check_eq("rst_no_resp", 32'(resp_n - r0), 32'd0);
        check_eq("rst_mem", mem[14'h10], snap);

        // Back-to-back loads with req_valid held; second address wraps
        poke(14'h10, 32'hCAFE_0001);
        begin
            exp_t e;
            e.data = 32'hCAFE_0001; e.mis = 1'b0;
            sb_q.push_back(e); sb_q.push_back(e);
        end
        @(posedge clock); #1;
        wait_ready();
        acc_log.delete();
        r0 = resp_n; a0 = acc_n;
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010;
        req_address = 32'h40;
        @(posedge clock); #1;
        req_address = 32'h0001_0040;
        for (k = 0; k < 20; k++) begin
            if (acc_n >= a0 + 2) break;
            @(posedge clock); #1;
        end
        req_valid = 1'b0;
        check_eq("hold_accepts", 32'(acc_n - a0), 32'd2);
        wait_resp(r0 + 2);
        check_eq("wrap_addr", 32'(c1_addr), 32'h10);
        if (acc_log.size() >= 2)
            check_eq("accept_spacing", 32'(acc_log[1] - acc_log[0]), 32'd4);
        else
            check_eq("accept_log", 32'(acc_log.size()), 32'd2);
        repeat (3) @(posedge clock);
        #1;
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
